// File: rtl/uart_echo_ctrl.sv
// Echo sequencer for the CoreUART byte interface: drains RX bytes into a FIFO
// and writes them back for transmit in arrival order. Reads beat writes.
module uart_echo_ctrl #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int HOLDOFF = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clr_ovf,
  input  logic          uart_rxrdy,
  input  logic          uart_txrdy,
  input  logic [7:0]    uart_data_out,
  output logic          uart_oen,
  output logic          uart_wen,
  output logic [7:0]    uart_data_in,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic          busy
);

  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    RD_SETTLE = 3'd2,
    WR        = 3'd3,
    WR_HOLD   = 3'd4
  } state_t;

  // Handshake: CoreUART raises rxrdy/txrdy as "valid/ready"; this block answers
  // with a single-cycle active-low oen (read) or wen (write), never both at once.
  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [HW-1:0] hold_cnt;
  logic          full;
  logic          empty;
  logic          push;

  assign full  = (fifo_count == (AW + 1)'(DEPTH));
  assign empty = (fifo_count == '0);
  assign push  = (state == RD) && !full;

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= uart_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      uart_oen     <= 1'b1;
      uart_wen     <= 1'b1;
      uart_data_in <= 8'h00;
      fifo_count   <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      hold_cnt     <= '0;
    end else begin
      // A drop in RD is assigned later in this block, so it overrides a clear.
      if (clr_ovf) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable && uart_rxrdy) begin
            state    <= RD;
            uart_oen <= 1'b0;
            busy     <= 1'b1;
          end else if (enable && !empty && uart_txrdy) begin
            state        <= WR;
            uart_wen     <= 1'b0;
            uart_data_in <= mem[rptr];
            busy         <= 1'b1;
          end
        end

        RD: begin
          uart_oen <= 1'b1;
          state    <= RD_SETTLE;
          if (!full) begin
            wptr       <= wptr + 1'b1;
            fifo_count <= fifo_count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end

        RD_SETTLE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        WR: begin
          uart_wen   <= 1'b1;
          rptr       <= rptr + 1'b1;
          fifo_count <= fifo_count - 1'b1;
          hold_cnt   <= HW'(HOLDOFF);
          state      <= WR_HOLD;
        end

        WR_HOLD: begin
          // txrdy may still show the previous byte's status until the holdoff expires.
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (uart_txrdy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          uart_oen <= 1'b1;
          uart_wen <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: cycle table for a single echo, then directed
// sequences for overflow, priority, wrap-around, reset and disable.
module tb_uart_echo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       clr_ovf = 1'b0;
  logic       uart_rxrdy = 1'b0;
  logic       uart_txrdy = 1'b1;
  logic [7:0] uart_data_out = 8'h00;
  logic       uart_oen;
  logic       uart_wen;
  logic [7:0] uart_data_in;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int oen_pulses = 0;
  int wen_pulses = 0;
  logic prev_oen = 1'b1;
  logic prev_wen = 1'b1;
  logic [7:0] exp_q[$];

  uart_echo_ctrl #(.DEPTH(16), .AW(4), .HOLDOFF(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clr_ovf       (clr_ovf),
    .uart_rxrdy    (uart_rxrdy),
    .uart_txrdy    (uart_txrdy),
    .uart_data_out (uart_data_out),
    .uart_oen      (uart_oen),
    .uart_wen      (uart_wen),
    .uart_data_in  (uart_data_in),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .busy          (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // strobe monitor and write scoreboard
  always @(negedge clk) begin
    if (!uart_oen || !uart_wen) chk("strobe_overlap", 32'(uart_oen | uart_wen), 32'd1);
    if (!uart_oen) begin
      oen_pulses++;
      chk("oen_width", 32'(prev_oen), 32'd1);
    end
    if (!uart_wen) begin
      wen_pulses++;
      chk("wen_width", 32'(prev_wen), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_data: got %0h expected no write", uart_data_in);
      end else begin
        chk("wr_data", 32'(uart_data_in), 32'(exp_q.pop_front()));
      end
    end
    prev_oen = uart_oen;
    prev_wen = uart_wen;
  end

  // driver tasks
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic clr_at_read);
    bit got;
    got = 1'b0;
    uart_data_out = b;
    uart_rxrdy = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      #1;
      if (!uart_oen) got = 1'b1;
    end
    chk("rx_handshake", 32'(got), 32'd1);
    uart_rxrdy = 1'b0;
    clr_ovf = clr_at_read;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (fifo_count == 5'd0 && !busy) done = 1'b1;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic pulse_clr();
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
  endtask

  typedef struct packed {
    logic       rxrdy;
    logic       txrdy;
    logic [7:0] data;
    logic       exp_oen;
    logic       exp_wen;
    logic [7:0] exp_din;
    logic [4:0] exp_cnt;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int oen0;
    int wen0;
    bit seen;

    // single echo of A5, one row per clock edge
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'h00, 5'd1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'h00, 5'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b0};

    // reset values
    cycles(3);
    chk("rst_oen", 32'(uart_oen), 32'd1);
    chk("rst_wen", 32'(uart_wen), 32'd1);
    chk("rst_din", 32'(uart_data_in), 32'h00);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // 1: echo one byte
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 10; i++) begin
      uart_rxrdy = vecs[i].rxrdy;
      uart_txrdy = vecs[i].txrdy;
      uart_data_out = vecs[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          32'({uart_oen, uart_wen, uart_data_in, fifo_count, busy}),
          32'({vecs[i].exp_oen, vecs[i].exp_wen, vecs[i].exp_din, vecs[i].exp_cnt, vecs[i].exp_busy}));
    end

    // 2: overflow, including clear and drop landing on the same edge
    uart_txrdy = 1'b0;
    oen0 = oen_pulses;
    for (int i = 0; i < 18; i++) rx_byte(8'(i), 1'b0);
    chk("ovf_count_full", 32'(fifo_count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    cycles(1);
    pulse_clr();
    rx_byte(8'h12, 1'b1);
    chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
    rx_byte(8'h13, 1'b0);
    chk("ovf_oen_pulses", 32'(oen_pulses - oen0), 32'd20);
    chk("ovf_count_after", 32'(fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    wen0 = wen_pulses;
    uart_txrdy = 1'b1;
    wait_drain(400);
    chk("ovf_wen_pulses", 32'(wen_pulses - wen0), 32'd16);
    chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6b: clear after overflow
    pulse_clr();

    // 3: read wins over write
    uart_txrdy = 1'b0;
    rx_byte(8'h31, 1'b0);
    rx_byte(8'h32, 1'b0);
    cycles(1);
    chk("prio_count", 32'(fifo_count), 32'd2);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h33);
    wen0 = wen_pulses;
    uart_data_out = 8'h33;
    uart_rxrdy = 1'b1;
    uart_txrdy = 1'b1;
    @(posedge clk);
    #1;
    chk("prio_rd_first", 32'({uart_oen, uart_wen}), 32'b01);
    uart_rxrdy = 1'b0;
    wait_drain(200);
    chk("prio_wen_pulses", 32'(wen_pulses - wen0), 32'd3);

    // 4: wrap-around
    wen0 = wen_pulses;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(i * 7 + 3));
      rx_byte(8'(i * 7 + 3), 1'b0);
      wait_drain(50);
    end
    chk("wrap_wen_pulses", 32'(wen_pulses - wen0), 32'd40);
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_no_ovf", 32'(overflow), 32'd0);

    // 5: reset during WR_HOLD
    uart_txrdy = 1'b0;
    rx_byte(8'h51, 1'b0);
    rx_byte(8'h52, 1'b0);
    rx_byte(8'h53, 1'b0);
    cycles(1);
    chk("rstw_count", 32'(fifo_count), 32'd3);
    exp_q.push_back(8'h51);
    wen0 = wen_pulses;
    uart_txrdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (!uart_wen) seen = 1'b1;
    end
    chk("rstw_wr_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_oen", 32'(uart_oen), 32'd1);
    chk("rstw_wen", 32'(uart_wen), 32'd1);
    chk("rstw_cnt", 32'(fifo_count), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("rstw_wen_pulses", 32'(wen_pulses - wen0), 32'd1);
    chk("rstw_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: disable holds IDLE and preserves the FIFO
    uart_txrdy = 1'b0;
    rx_byte(8'h66, 1'b0);
    cycles(1);
    enable = 1'b0;
    oen0 = oen_pulses;
    wen0 = wen_pulses;
    uart_data_out = 8'h77;
    uart_rxrdy = 1'b1;
    uart_txrdy = 1'b1;
    cycles(10);
    chk("dis_no_oen", 32'(oen_pulses - oen0), 32'd0);
    chk("dis_no_wen", 32'(wen_pulses - wen0), 32'd0);
    chk("dis_count", 32'(fifo_count), 32'd1);
    chk("dis_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h77);
    enable = 1'b1;
    rx_byte(8'h77, 1'b0);
    wait_drain(200);
    chk("dis_resume_wen", 32'(wen_pulses - wen0), 32'd2);
    chk("dis_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
